// File: rtl/vector_seq_pkg.sv
// Shared types and default widths for the test-vector sequencer.
package vector_seq_pkg;

    localparam int unsigned SETTLE_W   = 8;
    localparam int unsigned DEF_IN_W   = 6;
    localparam int unsigned DEF_OUT_W  = 7;
    localparam int unsigned DEF_SETTLE = 2;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StReport,
        StDone
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import vector_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] out
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = r_cnt;

endmodule

// File: rtl/vector_seq_ctrl.sv
// Test-vector sequencer: drives stimulus onto a CUT, waits a settle time, then
// compares masked CUT outputs against expected values and reports the result.
module vector_seq_ctrl
    import vector_seq_pkg::*;
#(
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned SETTLE = DEF_SETTLE,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  vec_in,
    input  logic [OUT_W-1:0] vec_exp,
    input  logic [OUT_W-1:0] vec_mask,
    input  logic             vec_last,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_fail,
    output logic [OUT_W-1:0] res_diff,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count
);

    seq_state_e          r_state;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [IN_W-1:0]     r_dut_in;
    logic [OUT_W-1:0]    r_exp;
    logic [OUT_W-1:0]    r_mask;
    logic                r_last;
    logic [OUT_W-1:0]    r_res_diff;
    logic                r_res_fail;
    logic                r_res_valid;
    logic                r_done;

    logic [OUT_W-1:0]    w_diff;
    logic                w_sample;
    logic                w_clr;

    assign w_diff   = (dut_out ^ r_exp) & r_mask;
    assign w_sample = (r_state == StSettle) && (r_settle_cnt == '0) && !abort;
    assign w_clr    = start && !abort && ((r_state == StIdle) || (r_state == StDone));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_settle_cnt <= '0;
            r_dut_in     <= '0;
            r_exp        <= '0;
            r_mask       <= '0;
            r_last       <= 1'b0;
            r_res_diff   <= '0;
            r_res_fail   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            // Counters, dut_in and the last result are deliberately kept.
            r_state     <= StIdle;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StLoad;
                        r_done  <= 1'b0;
                    end
                end
                StLoad: begin
                    if (vec_valid) begin
                        r_dut_in     <= vec_in;
                        r_exp        <= vec_exp;
                        r_mask       <= vec_mask;
                        r_last       <= vec_last;
                        r_settle_cnt <= SETTLE_W'(SETTLE - 1);
                        r_state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_settle_cnt == '0) begin
                        r_res_diff  <= w_diff;
                        r_res_fail  <= |w_diff;
                        r_res_valid <= 1'b1;
                        r_state     <= StReport;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                StReport: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StLoad;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sample),
        .clr   (w_clr),
        .out   (vec_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sample && (|w_diff)),
        .clr   (w_clr),
        .out   (err_count)
    );

    assign vec_ready = (r_state == StLoad) && !abort;
    assign busy      = (r_state != StIdle) && (r_state != StDone);
    assign dut_in    = r_dut_in;
    assign res_valid = r_res_valid;
    assign res_fail  = r_res_fail;
    assign res_diff  = r_res_diff;
    assign done      = r_done;

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Directed bench for vector_seq_ctrl; CUT modelled as dut_out = {1'b0, dut_in}.
module tb_vector_seq_ctrl;

    localparam int unsigned IN_W   = 6;
    localparam int unsigned OUT_W  = 7;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SAT_W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, abort, vec_valid, vec_last, res_ready;
    logic [IN_W-1:0]  vec_in;
    logic [OUT_W-1:0] vec_exp, vec_mask;

    logic             vec_ready, res_valid, res_fail, busy, done;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out, res_diff;
    logic [CNT_W-1:0] vec_count, err_count;

    logic             s_vec_ready, s_res_valid, s_res_fail, s_busy, s_done;
    logic [IN_W-1:0]  s_dut_in;
    logic [OUT_W-1:0] s_dut_out, s_res_diff;
    logic [SAT_W-1:0] s_vec_count, s_err_count;

    assign dut_out   = {1'b0, dut_in};
    assign s_dut_out = {1'b0, s_dut_in};

    vector_seq_ctrl #(
        .IN_W (IN_W), .OUT_W (OUT_W), .SETTLE (SETTLE), .CNT_W (CNT_W)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .vec_valid (vec_valid), .vec_ready (vec_ready), .vec_in (vec_in),
        .vec_exp (vec_exp), .vec_mask (vec_mask), .vec_last (vec_last),
        .dut_in (dut_in), .dut_out (dut_out), .res_valid (res_valid),
        .res_ready (res_ready), .res_fail (res_fail), .res_diff (res_diff),
        .busy (busy), .done (done), .vec_count (vec_count), .err_count (err_count)
    );

    // Narrow-counter copy driven by the same stimulus, for saturation checks.
    vector_seq_ctrl #(
        .IN_W (IN_W), .OUT_W (OUT_W), .SETTLE (SETTLE), .CNT_W (SAT_W)
    ) u_dut_sat (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .vec_valid (vec_valid), .vec_ready (s_vec_ready), .vec_in (vec_in),
        .vec_exp (vec_exp), .vec_mask (vec_mask), .vec_last (vec_last),
        .dut_in (s_dut_in), .dut_out (s_dut_out), .res_valid (s_res_valid),
        .res_ready (res_ready), .res_fail (s_res_fail), .res_diff (s_res_diff),
        .busy (s_busy), .done (s_done), .vec_count (s_vec_count),
        .err_count (s_err_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one vector in LOAD; returns with the result sitting in REPORT.
    task automatic send_vec(input logic [IN_W-1:0] vin, input logic [OUT_W-1:0] vexp,
                            input logic [OUT_W-1:0] vmask, input logic vlast);
        vec_valid = 1'b1;
        vec_in    = vin;
        vec_exp   = vexp;
        vec_mask  = vmask;
        vec_last  = vlast;
        tick();
        vec_valid = 1'b0;
        repeat (SETTLE) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    logic [IN_W-1:0]  s_in  [4];
    logic [OUT_W-1:0] s_exp [4];
    int               t_acc [4];
    int               idx, cyc, t_done;
    logic             acc;
    logic [IN_W-1:0]  vi;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
        res_ready = 1'b1; vec_in = '0; vec_exp = '0; vec_mask = '0;
        #12;
        check_eq("rst_dut_in", 32'(dut_in), 32'h0);
        check_eq("rst_flags", 32'({res_valid, res_fail, vec_ready, busy, done}), 32'h0);
        check_eq("rst_counts", 32'({vec_count, err_count}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single matching vector
        do_start();
        check_eq("load_ready", 32'(vec_ready), 32'h1);
        check_eq("load_busy", 32'(busy), 32'h1);
        vec_valid = 1'b1; vec_in = 6'h2A; vec_exp = 7'h2A; vec_mask = 7'h7F; vec_last = 1'b1;
        tick();
        vec_valid = 1'b0;
        check_eq("single_dut_in", 32'(dut_in), 32'h2A);
        check_eq("single_no_ready", 32'(vec_ready), 32'h0);
        check_eq("single_rv_e0", 32'(res_valid), 32'h0);
        tick();
        check_eq("single_rv_e1", 32'(res_valid), 32'h0);
        tick();
        check_eq("single_rv_e2", 32'(res_valid), 32'h1);
        check_eq("single_fail", 32'(res_fail), 32'h0);
        check_eq("single_counts", 32'({vec_count, err_count}), 32'h0001_0000);
        tick();
        check_eq("single_done", 32'(done), 32'h1);
        check_eq("single_idle_busy", 32'(busy), 32'h0);
        check_eq("single_rv_drop", 32'(res_valid), 32'h0);

        // Masked mismatch, then the same mismatch masked out
        do_start();
        check_eq("restart_clr_done", 32'(done), 32'h0);
        check_eq("restart_clr_cnt", 32'(vec_count), 32'h0);
        send_vec(6'h2A, 7'h2B, 7'h01, 1'b1);
        check_eq("mask01_fail", 32'(res_fail), 32'h1);
        check_eq("mask01_diff", 32'(res_diff), 32'h01);
        tick();
        do_start();
        send_vec(6'h2A, 7'h2B, 7'h7E, 1'b1);
        check_eq("mask7e_fail", 32'(res_fail), 32'h0);
        check_eq("mask7e_diff", 32'(res_diff), 32'h00);
        tick();

        // Four-vector stream, mismatch on the third
        s_in  = '{6'h01, 6'h02, 6'h03, 6'h04};
        s_exp = '{7'h01, 7'h02, 7'h13, 7'h04};
        do_start();
        idx = 0; cyc = 0; t_done = -1;
        t_acc = '{0, 0, 0, 0};
        vec_valid = 1'b1; vec_mask = 7'h7F;
        while (t_done < 0 && cyc < 40) begin
            if (idx < 4) begin
                vec_in = s_in[idx]; vec_exp = s_exp[idx]; vec_last = (idx == 3);
            end
            acc = vec_valid && vec_ready;
            tick();
            cyc++;
            if (acc && idx < 4) begin
                t_acc[idx] = cyc;
                idx++;
            end
            if (done) t_done = cyc;
        end
        vec_valid = 1'b0;
        check_eq("stream_accepts", 32'(idx), 32'd4);
        check_eq("stream_gap01", 32'(t_acc[1] - t_acc[0]), 32'd4);
        check_eq("stream_gap12", 32'(t_acc[2] - t_acc[1]), 32'd4);
        check_eq("stream_gap23", 32'(t_acc[3] - t_acc[2]), 32'd4);
        check_eq("stream_done_lat", 32'(t_done - t_acc[3]), 32'd3);
        check_eq("stream_vec_cnt", 32'(vec_count), 32'd4);
        check_eq("stream_err_cnt", 32'(err_count), 32'd1);
        check_eq("stream_dut_in", 32'(dut_in), 32'h04);
        check_eq("stream_sat_vec", 32'(s_vec_count), 32'd3);

        // Backpressure on the result
        do_start();
        res_ready = 1'b0;
        send_vec(6'h05, 7'h15, 7'h7F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rv", 32'(res_valid), 32'h1);
            check_eq("bp_diff", 32'(res_diff), 32'h10);
            check_eq("bp_ready", 32'(vec_ready), 32'h0);
            check_eq("bp_count", 32'(vec_count), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check_eq("bp_release_rv", 32'(res_valid), 32'h0);
        check_eq("bp_release_load", 32'(vec_ready), 32'h1);
        check_eq("bp_counts", 32'({vec_count, err_count}), 32'h0001_0001);

        // Abort during SETTLE
        vec_valid = 1'b1; vec_in = 6'h06; vec_exp = 7'h06; vec_last = 1'b0;
        tick();
        vec_valid = 1'b0;
        check_eq("abort_pre_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_idle", 32'(busy), 32'h0);
        check_eq("abort_rv", 32'(res_valid), 32'h0);
        check_eq("abort_done", 32'(done), 32'h0);
        check_eq("abort_counts", 32'({vec_count, err_count}), 32'h0001_0001);
        check_eq("abort_dut_in", 32'(dut_in), 32'h06);
        repeat (2) tick();
        check_eq("abort_rv_late", 32'(res_valid), 32'h0);
        do_start();
        check_eq("abort_restart_cnt", 32'({vec_count, err_count}), 32'h0);
        abort = 1'b1; vec_valid = 1'b1; vec_in = 6'h07;
        #1;
        check_eq("abort_blocks_ready", 32'(vec_ready), 32'h0);
        tick();
        abort = 1'b0; vec_valid = 1'b0;
        check_eq("abort_no_accept", 32'(dut_in), 32'h06);
        check_eq("abort_load_idle", 32'(busy), 32'h0);

        // Five failing vectors: the narrow counters stick at 3
        do_start();
        for (int i = 0; i < 5; i++) begin
            vi = IN_W'(i + 1);
            send_vec(vi, {1'b0, vi} ^ 7'h01, 7'h7F, i == 4);
            check_eq("sat_fail", 32'(res_fail), 32'h1);
            tick();
        end
        check_eq("sat_done", 32'(done), 32'h1);
        check_eq("sat_wide_vec", 32'(vec_count), 32'd5);
        check_eq("sat_wide_err", 32'(err_count), 32'd5);
        check_eq("sat_vec", 32'(s_vec_count), 32'd3);
        check_eq("sat_err", 32'(s_err_count), 32'd3);

        // Asynchronous reset mid-SETTLE
        do_start();
        vec_valid = 1'b1; vec_in = 6'h3F; vec_exp = 7'h00; vec_last = 1'b1;
        tick();
        vec_valid = 1'b0;
        check_eq("arst_pre_dut_in", 32'(dut_in), 32'h3F);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dut_in", 32'(dut_in), 32'h0);
        check_eq("arst_flags", 32'({res_valid, res_fail, vec_ready, busy, done}), 32'h0);
        check_eq("arst_diff", 32'(res_diff), 32'h0);
        check_eq("arst_counts", 32'({vec_count, err_count}), 32'h0);
        check_eq("arst_sat_counts", 32'({s_vec_count, s_err_count}), 32'h0);
        #3 rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
